// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: shares the video-RAM Wishbone master between port 0 (video_out_read,
// fills the output pixel fifo) and port 1 (video_in frame writer).
// Round-robin arbitration with a burst cap, plus an urgent override for port 0.
// Define WB_ARB_STATS_EN to build the wait1_cnt / xfer0_cnt statistics outputs.
module wb_ram_arbiter #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             urgent0,
   input  logic             m0_CYC_I,
   input  logic             m0_STB_I,
   input  logic             m0_LOCK_I,
   input  logic             m0_WE_I,
   input  logic [3:0]       m0_SEL_I,
   input  logic [31:0]      m0_ADR_I,
   input  logic [31:0]      m0_DAT_I,
   output logic             m0_ACK_O,
   output logic [31:0]      m0_DAT_O,
   input  logic             m1_CYC_I,
   input  logic             m1_STB_I,
   input  logic             m1_LOCK_I,
   input  logic             m1_WE_I,
   input  logic [3:0]       m1_SEL_I,
   input  logic [31:0]      m1_ADR_I,
   input  logic [31:0]      m1_DAT_I,
   output logic             m1_ACK_O,
   output logic [31:0]      m1_DAT_O,
   output logic             p_wb_CYC_O,
   output logic             p_wb_STB_O,
   output logic             p_wb_LOCK_O,
   output logic             p_wb_WE_O,
   output logic [3:0]       p_wb_SEL_O,
   output logic [31:0]      p_wb_ADR_O,
   output logic [31:0]      p_wb_DAT_O,
   input  logic             p_wb_ACK_I,
   input  logic [31:0]      p_wb_DAT_I,
   output logic [1:0]       gnt
`ifdef WB_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] wait1_cnt,
   output logic [CNT_W-1:0] xfer0_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

   localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

   state_e     state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   logic       at_cap, rel0, rel1;

   // Release conditions; a grant never changes in a cycle carrying an ACK
   always_comb begin
      at_cap = (burst_cnt_q == MaxBurst);
      rel0   = !m0_CYC_I || (at_cap && m1_CYC_I && !m0_LOCK_I && !p_wb_ACK_I);
      // Port 1 also yields early to an urgent port 0 unless locked
      rel1   = !m1_CYC_I ||
               (m0_CYC_I && !m1_LOCK_I && !p_wb_ACK_I && (at_cap || urgent0));
   end

   // Next-state logic for grant, round-robin pointer and burst counter
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (m0_CYC_I && m1_CYC_I) begin
               state_d = (urgent0 || last_q) ? StGnt0 : StGnt1;
            end else if (m0_CYC_I) begin
               state_d = StGnt0;
            end else if (m1_CYC_I) begin
               state_d = StGnt1;
            end
         end
         StGnt0: begin
            if (rel0) begin
               last_d  = 1'b0;
               state_d = m1_CYC_I ? StGnt1 : StIdle;
            end
         end
         StGnt1: begin
            if (rel1) begin
               last_d  = 1'b1;
               state_d = m0_CYC_I ? StGnt0 : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         burst_cnt_d = '0;
      end else if (p_wb_ACK_I && p_wb_STB_O && !at_cap) begin
         burst_cnt_d = burst_cnt_q + 8'd1;
      end
   end

   // Grant state, round-robin pointer and burst counter registers
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Route the granted port onto the shared bus; everything idles low otherwise
   always_comb begin
      p_wb_CYC_O  = 1'b0;
      p_wb_STB_O  = 1'b0;
      p_wb_LOCK_O = 1'b0;
      p_wb_WE_O   = 1'b0;
      p_wb_SEL_O  = '0;
      p_wb_ADR_O  = '0;
      p_wb_DAT_O  = '0;
      m0_ACK_O    = 1'b0;
      m1_ACK_O    = 1'b0;
      unique case (state_q)
         StGnt0: begin
            p_wb_CYC_O  = m0_CYC_I;
            p_wb_STB_O  = m0_STB_I;
            p_wb_LOCK_O = m0_LOCK_I;
            p_wb_WE_O   = m0_WE_I;
            p_wb_SEL_O  = m0_SEL_I;
            p_wb_ADR_O  = m0_ADR_I;
            p_wb_DAT_O  = m0_DAT_I;
            m0_ACK_O    = p_wb_ACK_I;
         end
         StGnt1: begin
            p_wb_CYC_O  = m1_CYC_I;
            p_wb_STB_O  = m1_STB_I;
            p_wb_LOCK_O = m1_LOCK_I;
            p_wb_WE_O   = m1_WE_I;
            p_wb_SEL_O  = m1_SEL_I;
            p_wb_ADR_O  = m1_ADR_I;
            p_wb_DAT_O  = m1_DAT_I;
            m1_ACK_O    = p_wb_ACK_I;
         end
         default: ;
      endcase
   end

   assign m0_DAT_O = p_wb_DAT_I;
   assign m1_DAT_O = p_wb_DAT_I;
   assign gnt      = {state_q == StGnt1, state_q == StGnt0};

`ifdef WB_ARB_STATS_EN
   // Saturating statistics: port-1 stall cycles and port-0 completed transfers
   always_ff @(posedge clk) begin
      if (RST) begin
         wait1_cnt <= '0;
         xfer0_cnt <= '0;
      end else begin
         if (m1_CYC_I && !gnt[1] && (wait1_cnt != '1)) begin
            wait1_cnt <= wait1_cnt + CNT_W'(1);
         end
         if (m0_ACK_O && (xfer0_cnt != '1)) begin
            xfer0_cnt <= xfer0_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
